// File: rtl/result_arbiter_pkg.sv
// Shared types for the result/writeback bus: physical register addressing and the result payload.
package result_arbiter_pkg;

  localparam int PREG    = 128;
  localparam int PREG_AW = 7;

  typedef logic [PREG_AW-1:0] preg_addr_t;

  typedef struct packed {
    logic [31:0] value;
    preg_addr_t  rd;
  } result_t;

endpackage

// File: rtl/result_arbiter_if.sv
// Result bus bundle: unit result streams in, broadcast bus and scoreboard out, rename allocation in.
interface result_arbiter_if
  import result_arbiter_pkg::*;
#(
  parameter int N_UNITS = 4
) ();

  logic [N_UNITS-1:0] unit_valid;
  logic [N_UNITS-1:0] unit_ready;
  result_t [N_UNITS-1:0] unit_data;
  logic               cdb_valid;
  result_t            cdb_data;
  logic               alloc_valid;
  preg_addr_t         alloc_addr;
  logic [PREG-1:0]    register_valid;

  modport master (
    output unit_valid, unit_data, alloc_valid, alloc_addr,
    input  unit_ready, cdb_valid, cdb_data, register_valid
  );

  modport slave (
    input  unit_valid, unit_data, alloc_valid, alloc_addr,
    output unit_ready, cdb_valid, cdb_data, register_valid
  );

endinterface

// File: rtl/result_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // k is the search distance from the pointer; the nearest requester wins
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Result bus arbiter: round-robin over execution-unit results onto a registered broadcast bus,
// plus the physical-register valid scoreboard. Define RESULT_ARB_PERF_EN to add perf counters.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int N_UNITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  result_arbiter_if.slave   bus
`ifdef RESULT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_results
`endif
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_UNITS-1:0] grant;
  logic               hs;
  result_t            win;
  logic               cdb_valid_q;
  result_t            cdb_data_q, cdb_data_d;
  logic [PREG-1:0]    sb_q, sb_d;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .req_i (bus.unit_valid),
    .ptr_i (ptr_q),
    .gnt_o (grant)
  );

  assign bus.unit_ready = reset ? grant : '0;

  always_comb begin
    hs    = 1'b0;
    win   = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N_UNITS; i++) begin
      if (grant[i]) begin
        hs    = 1'b1;
        win   = bus.unit_data[i];
        ptr_d = PTR_W'((i + 1) % N_UNITS);
      end
    end
  end

  // Set before clear so a same-cycle alloc of the destination wins; p0 never goes invalid
  always_comb begin
    sb_d = sb_q;
    if (hs) sb_d[win.rd] = 1'b1;
    if (bus.alloc_valid) sb_d[bus.alloc_addr] = 1'b0;
    sb_d[0] = 1'b1;
  end

  assign cdb_data_d = hs ? win : cdb_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      sb_q        <= '1;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= hs;
      cdb_data_q  <= cdb_data_d;
      sb_q        <= sb_d;
    end
  end

  assign bus.cdb_valid      = cdb_valid_q;
  assign bus.cdb_data       = cdb_data_q;
  assign bus.register_valid = sb_q;

`ifdef RESULT_ARB_PERF_EN
  logic [31:0] conflicts_q, results_q;
  logic        conflict;

  assign conflict = ($countones(bus.unit_valid) >= 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflicts_q <= '0;
      results_q   <= '0;
    end else begin
      if (conflict && (conflicts_q != 32'hFFFF_FFFF)) conflicts_q <= conflicts_q + 32'd1;
      if (hs && (results_q != 32'hFFFF_FFFF))         results_q   <= results_q + 32'd1;
    end
  end

  assign perf_conflicts = conflicts_q;
  assign perf_results   = results_q;
`endif

endmodule

// File: tb/tb_result_arbiter.sv
// Bench for result_arbiter: vector table, directed corner sequences and randomized traffic
// against a behavioural model of grant order, broadcast bus and scoreboard.
module tb_result_arbiter;
  import result_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_arbiter_if #(.N_UNITS(N)) bus ();

`ifdef RESULT_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_results;
`endif

  result_arbiter #(.N_UNITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RESULT_ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_results   (perf_results)
`endif
  );

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [PREG-1:0] m_sb;
  int              m_ptr;
  logic            m_cv;
  result_t         m_cd;
  longint          m_pc, m_pr;

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rdy;
    logic         cv;
    logic [6:0]   rd;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sb  = '1;
    m_ptr = 0;
    m_cv  = 1'b0;
    m_cd  = '0;
    m_pc  = 0;
    m_pr  = 0;
  endtask

  task automatic set_data(input int u, input logic [31:0] val, input logic [6:0] rd);
    result_t r;
    r.value = val;
    r.rd    = rd;
    bus.unit_data[u] = r;
  endtask

  // Called at posedge+1: drive, check grant, cross the edge, check registered state.
  task automatic step(input logic [N-1:0] v, input logic av, input logic [6:0] aa,
                      output logic [N-1:0] rdy_seen);
    int g;
    logic [N-1:0] er;
    bus.unit_valid  = v;
    bus.alloc_valid = av;
    bus.alloc_addr  = aa;
    #1;
    g  = model_grant(v);
    er = (g >= 0) ? (N'(1) << g) : '0;
    rdy_seen = bus.unit_ready;
    check("unit_ready", bus.unit_ready, er);
    @(posedge clk);
    if ($countones(v) >= 2) m_pc++;
    if (g >= 0) begin
      m_cd  = bus.unit_data[g];
      m_cv  = 1'b1;
      m_ptr = (g + 1) % N;
      m_pr++;
      m_sb[m_cd.rd] = 1'b1;
    end else begin
      m_cv = 1'b0;
    end
    if (av) m_sb[aa] = 1'b0;
    m_sb[0] = 1'b1;
    #1;
    check("cdb_valid", bus.cdb_valid, m_cv);
    check("cdb_data", bus.cdb_data, m_cd);
    check("register_valid", bus.register_valid, m_sb);
`ifdef RESULT_ARB_PERF_EN
    check("perf_conflicts", perf_conflicts, 32'(m_pc));
    check("perf_results", perf_results, 32'(m_pr));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rs;
    logic [PREG-1:0] ones;
    ones = '1;

    // expected grants from ptr=0, unit i carries rd=10+i
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 7'd0};
    tbl[1]  = '{4'b1111, 4'b0001, 1'b1, 7'd10};
    tbl[2]  = '{4'b1111, 4'b0010, 1'b1, 7'd11};
    tbl[3]  = '{4'b1111, 4'b0100, 1'b1, 7'd12};
    tbl[4]  = '{4'b1111, 4'b1000, 1'b1, 7'd13};
    tbl[5]  = '{4'b1111, 4'b0001, 1'b1, 7'd10};
    tbl[6]  = '{4'b0010, 4'b0010, 1'b1, 7'd11};
    tbl[7]  = '{4'b1010, 4'b1000, 1'b1, 7'd13};
    tbl[8]  = '{4'b1010, 4'b0010, 1'b1, 7'd11};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 7'd11};
    tbl[10] = '{4'b0001, 4'b0001, 1'b1, 7'd10};

    // reset state, with requests present to show ready is held low
    reset           = 1'b0;
    bus.unit_valid  = 4'b1111;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    for (int i = 0; i < N; i++) set_data(i, 32'(100 + i), 7'(10 + i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset unit_ready", bus.unit_ready, 4'b0000);
    check("reset cdb_valid", bus.cdb_valid, 1'b0);
    check("reset cdb_data", bus.cdb_data, 39'd0);
    check("reset register_valid", bus.register_valid, ones);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, 1'b0, 7'd0, rs);
      check($sformatf("tbl%0d ready", i), rs, tbl[i].rdy);
      check($sformatf("tbl%0d cdb_valid", i), bus.cdb_valid, tbl[i].cv);
      check($sformatf("tbl%0d cdb_rd", i), bus.cdb_data.rd, tbl[i].rd);
    end

    // alloc 20, then unit 2 delivers rd=20 five cycles later
    step(4'b0000, 1'b1, 7'd20, rs);
    check("alloc20 cleared", bus.register_valid[20], 1'b0);
    repeat (4) step(4'b0000, 1'b0, 7'd0, rs);
    set_data(2, 32'hCAFE_0020, 7'd20);
    step(4'b0100, 1'b0, 7'd0, rs);
    check("wake20 cdb_valid", bus.cdb_valid, 1'b1);
    check("wake20 set", bus.register_valid[20], 1'b1);

    // alloc and wakeup of the same register in one cycle
    set_data(1, 32'hCAFE_0030, 7'd30);
    step(4'b0010, 1'b1, 7'd30, rs);
    check("alloc30 wins", bus.register_valid[30], 1'b0);

    // p0 is immune to alloc
    step(4'b0000, 1'b1, 7'd0, rs);
    check("p0 stays valid", bus.register_valid[0], 1'b1);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < N; i++) set_data(i, 32'(200 + i), 7'(50 + i));
    step(4'b0001, 1'b1, 7'd60, rs);
    repeat (3) step(4'b1111, 1'b0, 7'd0, rs);
    check("burst cdb_valid", bus.cdb_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async cdb_valid", bus.cdb_valid, 1'b0);
    check("async register_valid", bus.register_valid, ones);
    check("async unit_ready", bus.unit_ready, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ten cycles of three concurrent requesters
    repeat (10) step(4'b0111, 1'b0, 7'd0, rs);
`ifdef RESULT_ARB_PERF_EN
    check("perf conflicts 10", perf_conflicts, 32'd10);
    check("perf results 10", perf_results, 32'd10);
`endif

    // randomized traffic with colliding destinations and allocations
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) set_data(i, $urandom, 7'($urandom_range(0, 40)));
      step(4'($urandom), ($urandom_range(0, 2) == 0), 7'($urandom_range(0, 40)), rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
